// File: rtl/paddle_input_if.sv
// ============================================================================
// Module   : paddle_input_if
// Purpose  : Controller-side inputs and paddle-position outputs for paddle_input.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface paddle_input_if;
    logic       v256;
    logic [1:0] mode1;
    logic [1:0] mode2;
    logic [7:0] axis1;
    logic [7:0] axis2;
    logic       up1;
    logic       up2;
    logic       down1;
    logic       down2;
    logic [7:0] spin1;
    logic [7:0] spin2;
    logic       spin1_stb;
    logic       spin2_stb;
    logic [7:0] paddle1_vpos;
    logic [7:0] paddle2_vpos;
    logic       frame_tick;

    modport master (
        output v256, mode1, mode2, axis1, axis2, up1, up2, down1, down2,
               spin1, spin2, spin1_stb, spin2_stb,
        input  paddle1_vpos, paddle2_vpos, frame_tick
    );

    modport slave (
        input  v256, mode1, mode2, axis1, axis2, up1, up2, down1, down2,
               spin1, spin2, spin1_stb, spin2_stb,
        output paddle1_vpos, paddle2_vpos, frame_tick
    );
endinterface

`default_nettype wire

// File: rtl/paddle_input.sv
// ============================================================================
// Module   : paddle_input
// Purpose  : Per-frame paddle position update from analog, digital or spinner input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module paddle_input #(
    parameter logic [7:0] PAD_MIN    = 8'd8,
    parameter logic [7:0] PAD_MAX    = 8'd232,
    parameter logic [7:0] RESET_POS  = 8'd120,
    parameter logic [7:0] DIG_STEP   = 8'd4,
    parameter int         SPIN_SHIFT = 0
) (
    input  wire logic     clk_sys,
    input  wire logic     reset,
    paddle_input_if.slave bus
);

    localparam logic signed [10:0] c_min     = {3'b000, PAD_MIN};
    localparam logic signed [10:0] c_max     = {3'b000, PAD_MAX};
    localparam logic signed [10:0] c_acc_max = 11'sd511;
    localparam logic signed [10:0] c_acc_min = -11'sd512;

    logic r_v256_prev;
    logic r_frame_tick;
    logic w_tick;

    // Edge-detect register resets high so a v256 already high at reset release is not a tick.
    assign w_tick = bus.v256 & ~r_v256_prev;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_v256_prev  <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_v256_prev  <= bus.v256;
            r_frame_tick <= w_tick;
        end
    end

    logic [1:0] w_mode [2];
    logic [7:0] w_axis [2];
    logic       w_up   [2];
    logic       w_down [2];
    logic [7:0] w_spin [2];
    logic       w_stb  [2];

    assign w_mode[0] = bus.mode1;      assign w_mode[1] = bus.mode2;
    assign w_axis[0] = bus.axis1;      assign w_axis[1] = bus.axis2;
    assign w_up[0]   = bus.up1;        assign w_up[1]   = bus.up2;
    assign w_down[0] = bus.down1;      assign w_down[1] = bus.down2;
    assign w_spin[0] = bus.spin1;      assign w_spin[1] = bus.spin2;
    assign w_stb[0]  = bus.spin1_stb;  assign w_stb[1]  = bus.spin2_stb;

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic        [7:0]  r_vpos;
        logic signed [9:0]  r_acc;
        logic signed [9:0]  w_acc_shift;
        logic signed [10:0] w_acc_sum;
        logic signed [9:0]  w_acc_sat;
        logic signed [9:0]  w_delta_ext;
        logic signed [10:0] w_base;
        logic signed [10:0] w_raw;
        logic        [7:0]  w_next;

        assign w_delta_ext = {{2{w_spin[p][7]}}, w_spin[p]};
        assign w_acc_shift = r_acc >>> SPIN_SHIFT;
        assign w_acc_sum   = {r_acc[9], r_acc} + {w_delta_ext[9], w_delta_ext};

        always_comb begin
            w_acc_sat = w_acc_sum[9:0];
            if (w_acc_sum > c_acc_max) begin
                w_acc_sat = 10'sd511;
            end else if (w_acc_sum < c_acc_min) begin
                w_acc_sat = -10'sd512;
            end
        end

        // 11-bit working value so position plus a saturated accumulator cannot wrap.
        always_comb begin
            w_base = {3'b000, r_vpos};
            w_raw  = w_base;
            case (w_mode[p])
                2'd0: w_raw = {3'b000, ~w_axis[p][7], w_axis[p][6:0]};
                2'd1: begin
                    if (w_up[p] && !w_down[p]) begin
                        w_raw = w_base - {3'b000, DIG_STEP};
                    end else if (w_down[p] && !w_up[p]) begin
                        w_raw = w_base + {3'b000, DIG_STEP};
                    end
                end
                2'd2: w_raw = w_base + {w_acc_shift[9], w_acc_shift};
                default: w_raw = w_base;
            endcase

            w_next = w_raw[7:0];
            if (w_raw < c_min) begin
                w_next = PAD_MIN;
            end else if (w_raw > c_max) begin
                w_next = PAD_MAX;
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_vpos <= RESET_POS;
                r_acc  <= '0;
            end else if (w_tick) begin
                r_vpos <= w_next;
                r_acc  <= w_stb[p] ? w_delta_ext : 10'sd0;
            end else if (w_stb[p]) begin
                r_acc  <= w_acc_sat;
            end
        end
    end

    assign bus.paddle1_vpos = g_player[0].r_vpos;
    assign bus.paddle2_vpos = g_player[1].r_vpos;
    assign bus.frame_tick   = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_paddle_input.sv
// ============================================================================
// Module   : tb_paddle_input
// Purpose  : Randomized and directed bench for paddle_input against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_paddle_input;
    localparam int PMIN  = 8;
    localparam int PMAX  = 232;
    localparam int PRST  = 120;
    localparam int STEP  = 4;
    localparam int SHIFT = 0;

    logic clk_sys;
    logic reset;
    paddle_input_if bus();

    paddle_input dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_tests = 0;
    int n_fail  = 0;

    int m_pos [2];
    int m_acc [2];
    bit m_prev;
    bit m_tick;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < PMIN) ? PMIN : ((v > PMAX) ? PMAX : v);
    endfunction

    function automatic int sat(input int v);
        return (v > 511) ? 511 : ((v < -512) ? -512 : v);
    endfunction

    function automatic int next_pos(input int pos, input int acc, input logic [1:0] mode,
                                    input logic [7:0] axis, input logic up, input logic down);
        int step;
        case (mode)
            2'd0: return clamp(int'($signed(axis)) + 128);
            2'd1: begin
                step = (up && !down) ? -STEP : ((down && !up) ? STEP : 0);
                return clamp(pos + step);
            end
            2'd2: return clamp(pos + (acc >>> SHIFT));
            default: return pos;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic cycle();
        logic [1:0] md [2];
        logic [7:0] ax [2];
        logic       u  [2];
        logic       d  [2];
        logic [7:0] sp [2];
        logic       sb [2];
        md[0] = bus.mode1;     md[1] = bus.mode2;
        ax[0] = bus.axis1;     ax[1] = bus.axis2;
        u[0]  = bus.up1;       u[1]  = bus.up2;
        d[0]  = bus.down1;     d[1]  = bus.down2;
        sp[0] = bus.spin1;     sp[1] = bus.spin2;
        sb[0] = bus.spin1_stb; sb[1] = bus.spin2_stb;
        if (reset) begin
            m_tick = 1'b0;
            m_prev = 1'b1;
            for (int p = 0; p < 2; p++) begin
                m_pos[p] = PRST;
                m_acc[p] = 0;
            end
        end else begin
            m_tick = bus.v256 && !m_prev;
            m_prev = bus.v256;
            for (int p = 0; p < 2; p++) begin
                if (m_tick) begin
                    m_pos[p] = next_pos(m_pos[p], m_acc[p], md[p], ax[p], u[p], d[p]);
                    m_acc[p] = sb[p] ? int'($signed(sp[p])) : 0;
                end else if (sb[p]) begin
                    m_acc[p] = sat(m_acc[p] + int'($signed(sp[p])));
                end
            end
        end
        @(posedge clk_sys);
        #1;
        chk("frame_tick", int'(bus.frame_tick), int'(m_tick));
        chk("vpos1", int'(bus.paddle1_vpos), m_pos[0]);
        chk("vpos2", int'(bus.paddle2_vpos), m_pos[1]);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic do_frame();
        bus.v256 = 1'b0;
        repeat (3) cycle();
        bus.v256 = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic strobe1(input logic [7:0] delta);
        bus.spin1 = delta;
        bus.spin1_stb = 1'b1;
        cycle();
        bus.spin1_stb = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.v256 = 1'b1;
        bus.mode1 = 2'd3;  bus.mode2 = 2'd3;
        bus.axis1 = 8'h00; bus.axis2 = 8'h00;
        bus.up1 = 1'b0;    bus.up2 = 1'b0;
        bus.down1 = 1'b0;  bus.down2 = 1'b0;
        bus.spin1 = 8'h00; bus.spin2 = 8'h00;
        bus.spin1_stb = 1'b0; bus.spin2_stb = 1'b0;

        // Reset with v256 high, then no tick while it stays high.
        do_reset(3);
        chk("reset_vpos1", int'(bus.paddle1_vpos), 120);
        chk("reset_vpos2", int'(bus.paddle2_vpos), 120);
        chk("reset_tick", int'(bus.frame_tick), 0);
        repeat (3) cycle();

        // Analog extremes and centre; tick one cycle after v256 rises.
        bus.mode1 = 2'd0;
        bus.axis1 = 8'h80; do_frame(); chk("analog_80", int'(bus.paddle1_vpos), 8);
        bus.axis1 = 8'h7F; do_frame(); chk("analog_7F", int'(bus.paddle1_vpos), 232);
        bus.axis1 = 8'h00;
        bus.v256 = 1'b0; repeat (2) cycle();
        bus.v256 = 1'b1; cycle();
        chk("tick_latency", int'(bus.frame_tick), 1);
        chk("analog_00", int'(bus.paddle1_vpos), 128);
        cycle();
        chk("tick_one_cycle", int'(bus.frame_tick), 0);

        // Digital.
        do_reset(1);
        bus.mode1 = 2'd1; bus.up1 = 1'b1;
        repeat (3) do_frame();
        chk("dig_up3", int'(bus.paddle1_vpos), 108);
        do_reset(1);
        bus.down1 = 1'b1;
        repeat (2) do_frame();
        chk("dig_both", int'(bus.paddle1_vpos), 120);
        bus.up1 = 1'b0;
        repeat (40) do_frame();
        chk("dig_down_sat", int'(bus.paddle1_vpos), 232);
        bus.down1 = 1'b0;

        // Spinner.
        do_reset(1);
        bus.mode1 = 2'd2;
        strobe1(8'd5); strobe1(8'd7);
        do_frame();
        chk("spin_12", int'(bus.paddle1_vpos), 132);
        repeat (10) strobe1(8'd127);
        do_frame();
        chk("spin_sat", int'(bus.paddle1_vpos), 232);
        do_reset(1);
        bus.v256 = 1'b0; repeat (3) cycle();
        bus.v256 = 1'b1; bus.spin1 = 8'd3; bus.spin1_stb = 1'b1;
        cycle();
        bus.spin1_stb = 1'b0;
        chk("spin_consume", int'(bus.paddle1_vpos), 120);
        repeat (2) cycle();
        do_frame();
        chk("spin_carry", int'(bus.paddle1_vpos), 123);

        // Independence and mid-frame mode change.
        do_reset(1);
        bus.mode1 = 2'd0; bus.axis1 = 8'h00;
        bus.mode2 = 2'd1; bus.down2 = 1'b1;
        do_frame();
        chk("indep_p1", int'(bus.paddle1_vpos), 128);
        chk("indep_p2", int'(bus.paddle2_vpos), 124);
        bus.down2 = 1'b0;
        bus.axis1 = 8'hC0;
        bus.v256 = 1'b0; repeat (2) cycle();
        bus.mode1 = 2'd3; cycle();
        bus.v256 = 1'b1; repeat (2) cycle();
        chk("mode_hold", int'(bus.paddle1_vpos), 128);
        bus.mode1 = 2'd0;
        do_frame();
        chk("mode_analog", int'(bus.paddle1_vpos), 64);

        // Reset with a pending accumulator.
        bus.mode1 = 2'd2;
        bus.v256 = 1'b0; cycle();
        strobe1(8'd40);
        do_reset(1);
        chk("midreset_vpos", int'(bus.paddle1_vpos), 120);
        do_frame();
        chk("midreset_acc", int'(bus.paddle1_vpos), 120);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.mode2 = 2'($urandom_range(0, 3));
            bus.axis1 = 8'($urandom); bus.axis2 = 8'($urandom);
            bus.up1 = 1'($urandom);   bus.up2 = 1'($urandom);
            bus.down1 = 1'($urandom); bus.down2 = 1'($urandom);
            bus.spin1 = 8'($urandom); bus.spin2 = 8'($urandom);
            bus.spin1_stb = ($urandom_range(0, 2) == 0);
            bus.spin2_stb = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) bus.v256 = ~bus.v256;
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
